// File: rtl/csnn_adc_pkg.sv
// csnn_adc_pkg: shared state encoding and fixed timing constants for the ADC read path.
package csnn_adc_pkg;
    typedef enum logic [2:0] {IDLE, CONV, CS_SETUP, SHIFT, DONE, QUIET} state_t;
    localparam int CONVST_CYC = 2;
    localparam int CSS_CYC    = 2;
    localparam int AVG_N      = 4;
endpackage

// File: rtl/adc_sck_gen.sv
// adc_sck_gen: serial clock divider, sck idles low and toggles every SCK_DIV cycles while enabled.
module adc_sck_gen #(
    parameter int SCK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);
    localparam int DIV_W = $clog2(SCK_DIV + 1);
    logic [DIV_W-1:0] r_div;
    logic             r_sck;
    logic             w_edge;
    // Strobes are high in the cycle whose closing edge flips sck.
    assign w_edge = i_en && r_div == DIV_W'(SCK_DIV - 1);
    assign o_rise = w_edge && !r_sck;
    assign o_fall = w_edge && r_sck;
    assign o_sck  = r_sck;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else if (!i_en) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else begin
            r_div <= w_edge ? '0 : r_div + 1'b1;
            r_sck <= r_sck ^ w_edge;
        end
    end
endmodule

// File: rtl/adc_rd16.sv
// adc_rd16: SPI-style read controller for a serial ADC (CONVST, wait, MSB-first shift, parallel word out).
// Define ADC_AVG_EN to average AVG_N back-to-back frames per request.
module adc_rd16
    import csnn_adc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SCK_DIV = 4,
    parameter int T_CONV  = 50,
    parameter int T_QUIET = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_state,
    input  logic              en_adc,
    input  logic              adc_sdo,
    output logic              adc_convst,
    output logic              adc_cs_n,
    output logic              adc_sck,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
);
    localparam int CNT_W = $clog2(T_CONV + DATA_W + T_QUIET + CSS_CYC + 1);
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              w_sck_en;
    logic              w_rise;
    logic              w_fall;
    // Gating with key_state forces sck low on the abort edge itself.
    assign w_sck_en = r_state == SHIFT && key_state;
    assign busy     = r_state != IDLE;
    adc_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_sck_en),
        .o_sck (adc_sck),
        .o_rise(w_rise),
        .o_fall(w_fall)
    );
`ifdef ADC_AVG_EN
    logic [DATA_W+1:0]         r_acc;
    logic [$clog2(AVG_N)-1:0]  r_frame;
    logic [DATA_W+1:0]         w_sum;
    assign w_sum = r_acc + {2'b00, r_shift};
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            adc_convst <= 1'b0;
            adc_cs_n   <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
`ifdef ADC_AVG_EN
            r_acc      <= '0;
            r_frame    <= '0;
`endif
        end else if (!key_state) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            adc_convst <= 1'b0;
            adc_cs_n   <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
`ifdef ADC_AVG_EN
            r_acc      <= '0;
            r_frame    <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (r_state)
                IDLE: if (en_adc) begin
                    r_state    <= CONV;
                    r_cnt      <= '0;
                    adc_convst <= 1'b1;
                end
                CONV: begin
                    adc_convst <= r_cnt < CNT_W'(CONVST_CYC - 1);
                    if (r_cnt == CNT_W'(T_CONV - 1)) begin
                        r_state  <= CS_SETUP;
                        r_cnt    <= '0;
                        adc_cs_n <= 1'b0;
                    end else r_cnt <= r_cnt + 1'b1;
                end
                CS_SETUP: if (r_cnt == CNT_W'(CSS_CYC - 1)) begin
                    r_state <= SHIFT;
                    r_cnt   <= '0;
                end else r_cnt <= r_cnt + 1'b1;
                // r_cnt counts sampled bits; the final sck fall closes the frame.
                SHIFT: begin
                    if (w_rise) begin
                        r_shift <= {r_shift[DATA_W-2:0], adc_sdo};
                        r_cnt   <= r_cnt + 1'b1;
                    end
                    if (w_fall && r_cnt == CNT_W'(DATA_W)) begin
                        r_state  <= DONE;
                        r_cnt    <= '0;
                        adc_cs_n <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= QUIET;
`ifdef ADC_AVG_EN
                    r_frame <= r_frame + 1'b1;
                    r_acc   <= r_frame == $bits(r_frame)'(AVG_N - 1) ? '0 : w_sum;
                    if (r_frame == $bits(r_frame)'(AVG_N - 1)) begin
                        data_out   <= w_sum[DATA_W+1:2];
                        data_valid <= 1'b1;
                    end
`else
                    data_out   <= r_shift;
                    data_valid <= 1'b1;
`endif
                end
                QUIET: if (r_cnt == CNT_W'(T_QUIET - 1)) begin
                    r_cnt <= '0;
`ifdef ADC_AVG_EN
                    r_state    <= r_frame != '0 ? CONV : IDLE;
                    adc_convst <= r_frame != '0;
`else
                    r_state <= IDLE;
`endif
                end else r_cnt <= r_cnt + 1'b1;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_rd16.sv
// tb_adc_rd16: directed bench for adc_rd16 with a behavioural serial ADC model.
module tb_adc_rd16;
`ifdef ADC_AVG_EN
    localparam int N_FR = 4;
    localparam int LAT  = 181 + 3 * 185;
`else
    localparam int N_FR = 1;
    localparam int LAT  = 181;
`endif
    localparam int T_QUIET = 4;
    logic        clk = 1'b0, rst_n = 1'b0, key_state = 1'b1, en_adc = 1'b0, adc_sdo = 1'b0;
    logic        adc_convst, adc_cs_n, adc_sck, data_valid, busy;
    logic [15:0] data_out;
    logic [15:0] q[$];
    logic [15:0] cur = 16'h0;
    int          n_tests = 0, n_fail = 0, n_valid = 0, n_rise = 0;

    always #5 clk = ~clk;

    adc_rd16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_state (key_state),
        .en_adc    (en_adc),
        .adc_sdo   (adc_sdo),
        .adc_convst(adc_convst),
        .adc_cs_n  (adc_cs_n),
        .adc_sck   (adc_sck),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy)
    );

    // ADC model: MSB driven on cs_n fall, next bit after each sck fall.
    always @(negedge adc_cs_n) begin
        cur     = (q.size() != 0) ? q.pop_front() : 16'h0;
        adc_sdo = cur[15];
    end
    always @(negedge adc_sck) if (!adc_cs_n) begin
        cur     = cur << 1;
        adc_sdo = cur[15];
    end
    always @(posedge adc_sck) n_rise++;
    always @(negedge clk) if (data_valid) n_valid++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        repeat (N_FR) q.push_back(w);
    endtask

    task automatic run_frame(input int pulse_at, output int lat);
        lat = 0;
        @(negedge clk) en_adc = 1'b1;
        @(posedge clk);
        #1 en_adc = 1'b0;
        for (int n = 1; n <= LAT + 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) chk("convst_hi", adc_convst, 1);
            if (n == 2) chk("convst_lo", adc_convst, 0);
            if (n == 49) chk("cs_conv", adc_cs_n, 1);
            if (n == 50) chk("cs_setup", adc_cs_n, 0);
            if (data_valid) begin
                lat = n;
                break;
            end
            en_adc = (n == pulse_at);
        end
        en_adc = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        while (busy && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    initial begin
        int lat, c, v0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_convst", adc_convst, 0);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sck", adc_sck, 0);
        chk("rst_data", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;

        push(16'hA5C3);
        n_rise = 0;
        run_frame(0, lat);
        chk("a5c3_lat", lat, LAT);
        chk("a5c3_data", data_out, 16'hA5C3);
        chk("a5c3_rises", n_rise, 16 * N_FR);
        @(posedge clk);
        #1;
        chk("valid_1cyc", data_valid, 0);
        chk("data_hold", data_out, 16'hA5C3);
        wait_idle(c);

        push(16'h0000);
        run_frame(0, lat);
        chk("zero_lat", lat, LAT);
        chk("zero_data", data_out, 16'h0000);
        en_adc = 1'b1;
        @(posedge clk);
        #1 en_adc = 1'b0;
        wait_idle(c);
        chk("quiet_len", 1 + c, T_QUIET);
        repeat (3) @(posedge clk);
        #1;
        chk("quiet_ignored", busy, 0);
        push(16'hFFFF);
        run_frame(0, lat);
        chk("ffff_lat", lat, LAT);
        chk("ffff_data", data_out, 16'hFFFF);
        wait_idle(c);

        push(16'h5A3C);
        v0 = n_valid;
        run_frame(100, lat);
        chk("shift_req_data", data_out, 16'h5A3C);
        wait_idle(c);
        repeat (5) @(posedge clk);
        #1;
        chk("shift_req_busy", busy, 0);
        chk("shift_req_one", n_valid - v0, 1);

        @(negedge clk) en_adc = 1'b1;
        @(posedge clk);
        #1 en_adc = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_convst", adc_convst, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_convst", adc_convst, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cs_n", adc_cs_n, 1);
        chk("arst_data", data_out, 0);
        @(negedge clk) rst_n = 1'b1;
        q.delete();
        push(16'h3C5A);
        run_frame(0, lat);
        chk("post_rst_lat", lat, LAT);
        chk("post_rst_data", data_out, 16'h3C5A);
        wait_idle(c);

        push(16'hC0DE);
        v0 = n_valid;
        @(negedge clk) en_adc = 1'b1;
        @(posedge clk);
        #1 en_adc = 1'b0;
        repeat (105) @(posedge clk);
        #1;
        chk("pre_abort_sck", adc_sck, 1);
        chk("pre_abort_cs", adc_cs_n, 0);
        key_state = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_cs_n", adc_cs_n, 1);
        chk("abort_sck", adc_sck, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", data_out, 0);
        repeat (5) @(posedge clk);
        #1 key_state = 1'b1;
        q.delete();
        chk("abort_no_valid", n_valid - v0, 0);

`ifdef ADC_AVG_EN
        q.push_back(16'd100);
        q.push_back(16'd101);
        q.push_back(16'd102);
        q.push_back(16'd103);
        v0 = n_valid;
        run_frame(0, lat);
        chk("avg_lat", lat, LAT);
        chk("avg_data", data_out, 16'd101);
        wait_idle(c);
        chk("avg_one_valid", n_valid - v0, 1);
        push(16'hFFFF);
        run_frame(0, lat);
        chk("avg_ffff", data_out, 16'hFFFF);
        wait_idle(c);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
